// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer
//
// Command sequencer behind an SPI slave byte engine. It decodes the received
// byte stream as a small SPI NOR flash command set and loads the response
// bytes back into the slave's shift-out register, so the FPGA looks like a
// serial flash to the host. Array reads are served from a backing memory
// through a single-outstanding request/valid port, with a one-byte prefetch
// buffer in front of the transmit path.
//
// Commands: 0x03 READ, 0x0B FAST_READ (one dummy byte), 0x9F JEDEC ID,
//           0x05 READ STATUS. Any other opcode pulses bad_cmd and the rest of
//           the frame is answered with IDLE_BYTE.
//
// Ports:
//   mclk          system clock (everything runs in this domain)
//   reset         synchronous, active-high
//   spi_cs        raw chip-select pin, active low (synchronized here)
//   spi_rx_strobe one-cycle pulse, spi_rx_data holds a received byte
//   spi_rx_data   received byte
//   spi_tx_strobe one-cycle pulse, load spi_tx_data into the shift-out reg
//   spi_tx_data   next byte to shift out
//   status_in     value answered to READ STATUS
//   mem_rd_req    one-cycle read request pulse
//   mem_addr      read address, held from mem_rd_req until mem_rd_valid
//   mem_rd_valid  one-cycle pulse, mem_rd_data is valid
//   mem_rd_data   read data
//   underrun      sticky: host clocked a data byte before memory supplied it
//   bad_cmd       one-cycle pulse on an unsupported opcode
module spi_flash_sequencer #(
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
    parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic        spi_rx_strobe,
    input  logic [7:0]  spi_rx_data,
    output logic        spi_tx_strobe,
    output logic [7:0]  spi_tx_data,
    input  logic [7:0]  status_in,
    output logic        mem_rd_req,
    output logic [23:0] mem_addr,
    input  logic        mem_rd_valid,
    input  logic [7:0]  mem_rd_data,
    output logic        underrun,
    output logic        bad_cmd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_ID,
        S_STATUS,
        S_IGNORE
    } state_t;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_JEDEC_ID  = 8'h9F;
    localparam logic [7:0] OP_STATUS    = 8'h05;

    // JEDEC ID split into bytes, MSB first.
    logic [7:0] jedec_byte [0:2];

    for (genvar gi = 0; gi < 3; gi++) begin : g_jedec
        assign jedec_byte[gi] = JEDEC_ID[23 - 8*gi -: 8];
    end

    // Registered state
    state_t      state_reg,      state_next;
    logic        cs_meta_reg;
    logic        cs_sync_reg;
    logic        fast_reg,       fast_next;
    logic [1:0]  addr_cnt_reg,   addr_cnt_next;
    logic [23:0] addr_acc_reg,   addr_acc_next;
    logic [1:0]  id_idx_reg,     id_idx_next;
    logic        tx_owed_reg,    tx_owed_next;
    logic        buf_valid_reg,  buf_valid_next;
    logic [7:0]  buf_data_reg,   buf_data_next;
    logic        rd_pending_reg, rd_pending_next;
    logic        stale_reg,      stale_next;
    logic        req_wait_reg,   req_wait_next;
    logic        tx_strobe_reg,  tx_strobe_next;
    logic [7:0]  tx_data_reg,    tx_data_next;
    logic        rd_req_reg,     rd_req_next;
    logic [23:0] mem_addr_reg,   mem_addr_next;
    logic        underrun_reg,   underrun_next;
    logic        bad_cmd_reg,    bad_cmd_next;

    // Combinational helpers
    logic        cs_abort;
    logic        valid_accept;
    logic        valid_fresh;
    logic        pending_after;
    logic        owed_set;
    logic        want_first_req;
    logic        fire;

    always_ff @(posedge mclk) begin
        if (reset) begin
            cs_meta_reg    <= 1'b1;
            cs_sync_reg    <= 1'b1;
            state_reg      <= S_IDLE;
            fast_reg       <= 1'b0;
            addr_cnt_reg   <= 2'd0;
            addr_acc_reg   <= 24'd0;
            id_idx_reg     <= 2'd0;
            tx_owed_reg    <= 1'b0;
            buf_valid_reg  <= 1'b0;
            buf_data_reg   <= 8'd0;
            rd_pending_reg <= 1'b0;
            stale_reg      <= 1'b0;
            req_wait_reg   <= 1'b0;
            tx_strobe_reg  <= 1'b0;
            tx_data_reg    <= IDLE_BYTE;
            rd_req_reg     <= 1'b0;
            mem_addr_reg   <= 24'd0;
            underrun_reg   <= 1'b0;
            bad_cmd_reg    <= 1'b0;
        end else begin
            cs_meta_reg    <= spi_cs;
            cs_sync_reg    <= cs_meta_reg;
            state_reg      <= state_next;
            fast_reg       <= fast_next;
            addr_cnt_reg   <= addr_cnt_next;
            addr_acc_reg   <= addr_acc_next;
            id_idx_reg     <= id_idx_next;
            tx_owed_reg    <= tx_owed_next;
            buf_valid_reg  <= buf_valid_next;
            buf_data_reg   <= buf_data_next;
            rd_pending_reg <= rd_pending_next;
            stale_reg      <= stale_next;
            req_wait_reg   <= req_wait_next;
            tx_strobe_reg  <= tx_strobe_next;
            tx_data_reg    <= tx_data_next;
            rd_req_reg     <= rd_req_next;
            mem_addr_reg   <= mem_addr_next;
            underrun_reg   <= underrun_next;
            bad_cmd_reg    <= bad_cmd_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        fast_next       = fast_reg;
        addr_cnt_next   = addr_cnt_reg;
        addr_acc_next   = addr_acc_reg;
        id_idx_next     = id_idx_reg;
        tx_owed_next    = tx_owed_reg;
        buf_valid_next  = buf_valid_reg;
        buf_data_next   = buf_data_reg;
        rd_pending_next = rd_pending_reg;
        stale_next      = stale_reg;
        req_wait_next   = req_wait_reg;
        tx_strobe_next  = 1'b0;
        tx_data_next    = tx_data_reg;
        rd_req_next     = 1'b0;
        mem_addr_next   = mem_addr_reg;
        underrun_next   = underrun_reg;
        bad_cmd_next    = 1'b0;
        owed_set        = 1'b0;
        want_first_req  = 1'b0;
        fire            = 1'b0;

        // Only a read we actually issued can complete; a completion of a read
        // that belonged to an aborted frame is swallowed here.
        valid_accept  = mem_rd_valid && rd_pending_reg;
        valid_fresh   = valid_accept && !stale_reg;
        pending_after = rd_pending_reg && !mem_rd_valid;
        cs_abort      = cs_sync_reg && (state_reg != S_IDLE);

        if (valid_accept) begin
            rd_pending_next = 1'b0;
            stale_next      = 1'b0;
        end
        if (valid_fresh) begin
            buf_valid_next = 1'b1;
            buf_data_next  = mem_rd_data;
        end

        if (cs_abort) begin
            // Frame ended: drop owed/buffered data and any deferred request.
            // A read still in flight is left to complete and then discarded.
            state_next     = S_IDLE;
            tx_owed_next   = 1'b0;
            buf_valid_next = 1'b0;
            req_wait_next  = 1'b0;
            if (pending_after) begin
                stale_next = 1'b1;
            end
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (!cs_sync_reg) begin
                        tx_strobe_next = 1'b1;
                        tx_data_next   = IDLE_BYTE;
                        state_next     = S_CMD;
                    end
                end
                S_CMD: begin
                    if (spi_rx_strobe) begin
                        unique case (spi_rx_data)
                            OP_READ, OP_FAST_READ: begin
                                state_next    = S_ADDR;
                                fast_next     = (spi_rx_data == OP_FAST_READ);
                                addr_cnt_next = 2'd0;
                            end
                            OP_JEDEC_ID: begin
                                state_next     = S_ID;
                                tx_strobe_next = 1'b1;
                                tx_data_next   = jedec_byte[0];
                                id_idx_next    = 2'd1;
                            end
                            OP_STATUS: begin
                                state_next     = S_STATUS;
                                tx_strobe_next = 1'b1;
                                tx_data_next   = status_in;
                            end
                            default: begin
                                state_next     = S_IGNORE;
                                tx_strobe_next = 1'b1;
                                tx_data_next   = IDLE_BYTE;
                                bad_cmd_next   = 1'b1;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (spi_rx_strobe) begin
                        addr_acc_next = {addr_acc_reg[15:0], spi_rx_data};
                        if (addr_cnt_reg == 2'd2) begin
                            want_first_req = 1'b1;
                            if (fast_reg) begin
                                tx_strobe_next = 1'b1;
                                tx_data_next   = IDLE_BYTE;
                                state_next     = S_DUMMY;
                            end else begin
                                owed_set   = 1'b1;
                                state_next = S_DATA;
                            end
                        end else begin
                            addr_cnt_next  = addr_cnt_reg + 2'd1;
                            tx_strobe_next = 1'b1;
                            tx_data_next   = IDLE_BYTE;
                        end
                    end
                end
                S_DUMMY: begin
                    if (spi_rx_strobe) begin
                        owed_set   = 1'b1;
                        state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    if (spi_rx_strobe) begin
                        owed_set = 1'b1;
                        // Previous byte was never loaded: host shifted out a
                        // stale byte. Still owe only one.
                        if (tx_owed_reg) begin
                            underrun_next = 1'b1;
                        end
                    end
                end
                S_ID: begin
                    if (spi_rx_strobe) begin
                        tx_strobe_next = 1'b1;
                        if (id_idx_reg == 2'd1) begin
                            tx_data_next = jedec_byte[1];
                            id_idx_next  = 2'd2;
                        end else if (id_idx_reg == 2'd2) begin
                            tx_data_next = jedec_byte[2];
                            id_idx_next  = 2'd3;
                        end else begin
                            tx_data_next = IDLE_BYTE;
                        end
                    end
                end
                S_STATUS: begin
                    if (spi_rx_strobe) begin
                        tx_strobe_next = 1'b1;
                        tx_data_next   = status_in;
                    end
                end
                S_IGNORE: begin
                    if (spi_rx_strobe) begin
                        tx_strobe_next = 1'b1;
                        tx_data_next   = IDLE_BYTE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase

            if (owed_set) begin
                tx_owed_next = 1'b1;
            end

            // Transmit rule: owed byte meets available data (either already
            // buffered or arriving this very cycle). The next sequential read
            // goes out in the same cycle so the buffer refills ahead of the host.
            fire = (tx_owed_reg || owed_set) && (buf_valid_reg || valid_fresh);
            if (fire) begin
                tx_strobe_next  = 1'b1;
                tx_data_next    = buf_valid_reg ? buf_data_reg : mem_rd_data;
                tx_owed_next    = 1'b0;
                buf_valid_next  = 1'b0;
                mem_addr_next   = mem_addr_reg + 24'd1;
                rd_req_next     = 1'b1;
                rd_pending_next = 1'b1;
            end

            // First read of a frame. If a read from an aborted frame is still
            // outstanding, hold the request (and mem_addr) until it returns.
            if (want_first_req) begin
                if (pending_after) begin
                    req_wait_next = 1'b1;
                end else begin
                    rd_req_next     = 1'b1;
                    rd_pending_next = 1'b1;
                    mem_addr_next   = {addr_acc_reg[15:0], spi_rx_data};
                end
            end else if (req_wait_reg && !pending_after) begin
                req_wait_next   = 1'b0;
                rd_req_next     = 1'b1;
                rd_pending_next = 1'b1;
                mem_addr_next   = addr_acc_reg;
            end
        end
    end

    assign spi_tx_strobe = tx_strobe_reg;
    assign spi_tx_data   = tx_data_reg;
    assign mem_rd_req    = rd_req_reg;
    assign mem_addr      = mem_addr_reg;
    assign underrun      = underrun_reg;
    assign bad_cmd       = bad_cmd_reg;

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Directed bench for spi_flash_sequencer: a host-side byte driver, a simple
// backing memory (data = addr[7:0] + 1, programmable latency) and a log of
// every byte loaded for transmission.
module tb_spi_flash_sequencer;

    logic        mclk = 1'b0;
    logic        reset;
    logic        spi_cs;
    logic        spi_rx_strobe;
    logic [7:0]  spi_rx_data;
    logic        spi_tx_strobe;
    logic [7:0]  spi_tx_data;
    logic [7:0]  status_in;
    logic        mem_rd_req;
    logic [23:0] mem_addr;
    logic        mem_rd_valid;
    logic [7:0]  mem_rd_data;
    logic        underrun;
    logic        bad_cmd;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  tx_q [$];
    logic [23:0] req_q [$];
    int          bad_cnt = 0;
    int          lat = 3;
    int          mem_cnt = 0;
    logic [23:0] mem_req_addr = 24'd0;
    int          overlap_err = 0;

    spi_flash_sequencer dut (
        .mclk          (mclk),
        .reset         (reset),
        .spi_cs        (spi_cs),
        .spi_rx_strobe (spi_rx_strobe),
        .spi_rx_data   (spi_rx_data),
        .spi_tx_strobe (spi_tx_strobe),
        .spi_tx_data   (spi_tx_data),
        .status_in     (status_in),
        .mem_rd_req    (mem_rd_req),
        .mem_addr      (mem_addr),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .underrun      (underrun),
        .bad_cmd       (bad_cmd)
    );

    always #5 mclk = ~mclk;

    // Transmit / bad_cmd monitor, sampled on the inactive edge.
    always @(negedge mclk) begin
        if (spi_tx_strobe) begin
            tx_q.push_back(spi_tx_data);
            $display("[%0t] tx load 0x%02h", $time, spi_tx_data);
        end
        if (bad_cmd) begin
            bad_cnt++;
        end
    end

    // Backing memory: one read at a time, valid `lat` cycles after the request.
    initial begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = 8'h00;
        forever begin
            @(posedge mclk);
            #1;
            mem_rd_valid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = mem_req_addr[7:0] + 8'd1;
                end
            end
            if (mem_rd_req) begin
                if (mem_cnt > 0) overlap_err++;
                mem_cnt      = lat;
                mem_req_addr = mem_addr;
                req_q.push_back(mem_addr);
                $display("[%0t] mem read req addr 0x%06h", $time, mem_addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // All host-side tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        spi_rx_data   = b;
        spi_rx_strobe = 1'b1;
        @(posedge mclk);
        #1;
        spi_rx_strobe = 1'b0;
        $display("[%0t] rx byte 0x%02h", $time, b);
    endtask

    // Drops CS and waits until the IDLE_BYTE load should be visible.
    task automatic cs_low();
        spi_cs = 1'b0;
        idle(3);
    endtask

    task automatic cs_high();
        spi_cs = 1'b1;
        idle(40);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        spi_cs = 1'b1;
        spi_rx_strobe = 1'b0;
        spi_rx_data = 8'h00;
        status_in = 8'h00;
        idle(3);
        vec_cnt++; if (spi_tx_strobe !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_strobe: got %b expected 0", spi_tx_strobe); end
        vec_cnt++; if (spi_tx_data !== 8'hFF) begin err_cnt++; $display("FAIL reset_tx_data: got %h expected ff", spi_tx_data); end
        vec_cnt++; if (mem_rd_req !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_rd_req: got %b expected 0", mem_rd_req); end
        vec_cnt++; if (mem_addr !== 24'h0) begin err_cnt++; $display("FAIL reset_mem_addr: got %h expected 000000", mem_addr); end
        vec_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        vec_cnt++; if (bad_cmd !== 1'b0) begin err_cnt++; $display("FAIL reset_bad_cmd: got %b expected 0", bad_cmd); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_jedec_id();
        logic [7:0] exp_q [$];
        tx_q.delete();
        bad_cnt = 0;
        spi_cs = 1'b0;
        idle(2);
        vec_cnt++; if (spi_tx_strobe !== 1'b0) begin err_cnt++; $display("FAIL cs_fall_early: got strobe %b expected 0", spi_tx_strobe); end
        idle(1);
        vec_cnt++; if (spi_tx_strobe !== 1'b1 || spi_tx_data !== 8'hFF) begin err_cnt++; $display("FAIL cs_fall_idle_byte: got %b/%h expected 1/ff", spi_tx_strobe, spi_tx_data); end
        send_byte(8'h9F);
        vec_cnt++; if (spi_tx_strobe !== 1'b1 || spi_tx_data !== 8'hEF) begin err_cnt++; $display("FAIL jedec_first: got %b/%h expected 1/ef", spi_tx_strobe, spi_tx_data); end
        for (int i = 0; i < 4; i++) begin
            idle(5);
            send_byte(8'h00);
        end
        idle(5);
        cs_high();
        exp_q = '{8'hFF, 8'hEF, 8'h40, 8'h18, 8'hFF, 8'hFF};
        vec_cnt++; if (tx_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL jedec_count: got %0d expected %0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vec_cnt++;
            if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL jedec_byte%0d: got %h expected %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]); end
        end
        vec_cnt++; if (bad_cnt != 0) begin err_cnt++; $display("FAIL jedec_bad_cmd: got %0d pulses expected 0", bad_cnt); end
    endtask

    task automatic test_read();
        logic [7:0]  exp_q [$];
        logic [23:0] exp_r [$];
        tx_q.delete();
        req_q.delete();
        lat = 3;
        cs_low();
        send_byte(8'h03); idle(5);
        send_byte(8'h00); idle(5);
        send_byte(8'h00); idle(5);
        send_byte(8'h10);
        vec_cnt++; if (mem_rd_req !== 1'b1 || mem_addr !== 24'h000010) begin err_cnt++; $display("FAIL read_first_req: got %b/%h expected 1/000010", mem_rd_req, mem_addr); end
        idle(3);
        vec_cnt++; if (spi_tx_strobe !== 1'b0) begin err_cnt++; $display("FAIL read_early_tx: got %b expected 0", spi_tx_strobe); end
        idle(1);
        vec_cnt++; if (spi_tx_strobe !== 1'b1 || spi_tx_data !== 8'h11) begin err_cnt++; $display("FAIL read_valid_to_tx: got %b/%h expected 1/11", spi_tx_strobe, spi_tx_data); end
        vec_cnt++; if (mem_rd_req !== 1'b1 || mem_addr !== 24'h000011) begin err_cnt++; $display("FAIL read_next_req: got %b/%h expected 1/000011", mem_rd_req, mem_addr); end
        for (int i = 0; i < 3; i++) begin
            idle(10);
            send_byte(8'h00);
        end
        idle(10);
        cs_high();
        exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h12, 8'h13, 8'h14};
        exp_r = '{24'h10, 24'h11, 24'h12, 24'h13, 24'h14};
        vec_cnt++; if (tx_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL read_tx_count: got %0d expected %0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vec_cnt++;
            if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL read_tx%0d: got %h expected %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]); end
        end
        for (int i = 0; i < exp_r.size(); i++) begin
            vec_cnt++;
            if (i >= req_q.size() || req_q[i] !== exp_r[i]) begin err_cnt++; $display("FAIL read_addr%0d: got %h expected %h", i, (i < req_q.size()) ? req_q[i] : 24'hxxxxxx, exp_r[i]); end
        end
        vec_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL read_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_fast_read_wrap();
        logic [7:0]  exp_q [$];
        logic [23:0] exp_r [$];
        tx_q.delete();
        req_q.delete();
        lat = 3;
        cs_low();
        send_byte(8'h0B); idle(5);
        send_byte(8'hFF); idle(5);
        send_byte(8'hFF); idle(5);
        send_byte(8'hFF);
        vec_cnt++; if (spi_tx_strobe !== 1'b1 || spi_tx_data !== 8'hFF) begin err_cnt++; $display("FAIL fast_dummy_slot: got %b/%h expected 1/ff", spi_tx_strobe, spi_tx_data); end
        vec_cnt++; if (mem_rd_req !== 1'b1 || mem_addr !== 24'hFFFFFF) begin err_cnt++; $display("FAIL fast_first_req: got %b/%h expected 1/ffffff", mem_rd_req, mem_addr); end
        idle(10);
        vec_cnt++; if (tx_q.size() != 4) begin err_cnt++; $display("FAIL fast_hold_before_dummy: got %0d loads expected 4", tx_q.size()); end
        send_byte(8'hA5);
        vec_cnt++; if (spi_tx_strobe !== 1'b1 || spi_tx_data !== 8'h00) begin err_cnt++; $display("FAIL fast_first_data: got %b/%h expected 1/00", spi_tx_strobe, spi_tx_data); end
        vec_cnt++; if (mem_rd_req !== 1'b1 || mem_addr !== 24'h000000) begin err_cnt++; $display("FAIL fast_wrap_addr: got %b/%h expected 1/000000", mem_rd_req, mem_addr); end
        for (int i = 0; i < 2; i++) begin
            idle(5);
            send_byte(8'h00);
        end
        idle(10);
        cs_high();
        exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h02};
        exp_r = '{24'hFFFFFF, 24'h000000, 24'h000001, 24'h000002};
        for (int i = 0; i < exp_q.size(); i++) begin
            vec_cnt++;
            if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL fast_tx%0d: got %h expected %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]); end
        end
        for (int i = 0; i < exp_r.size(); i++) begin
            vec_cnt++;
            if (i >= req_q.size() || req_q[i] !== exp_r[i]) begin err_cnt++; $display("FAIL fast_addr%0d: got %h expected %h", i, (i < req_q.size()) ? req_q[i] : 24'hxxxxxx, exp_r[i]); end
        end
    endtask

    task automatic test_underrun();
        tx_q.delete();
        lat = 20;
        cs_low();
        send_byte(8'h03); idle(5);
        send_byte(8'h00); idle(5);
        send_byte(8'h00); idle(5);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h00);
        vec_cnt++; if (underrun !== 1'b1) begin err_cnt++; $display("FAIL underrun_set: got %b expected 1", underrun); end
        idle(30);
        vec_cnt++; if (tx_q.size() != 4) begin err_cnt++; $display("FAIL underrun_tx_count: got %0d expected 4", tx_q.size()); end
        vec_cnt++; if (tx_q.size() < 4 || tx_q[3] !== 8'h21) begin err_cnt++; $display("FAIL underrun_late_data: got %h expected 21", (tx_q.size() >= 4) ? tx_q[3] : 8'hxx); end
        cs_high();
        vec_cnt++; if (underrun !== 1'b1) begin err_cnt++; $display("FAIL underrun_sticky: got %b expected 1", underrun); end
    endtask

    task automatic test_stale_cs();
        logic [7:0] exp_q [$];
        tx_q.delete();
        req_q.delete();
        lat = 20;
        // Part 1: abort mid-read, then a status command.
        cs_low();
        send_byte(8'h03); idle(5);
        send_byte(8'h00); idle(5);
        send_byte(8'h00); idle(5);
        send_byte(8'h30);
        idle(3);
        spi_cs = 1'b1;
        idle(5);
        status_in = 8'h5A;
        cs_low();
        send_byte(8'h05);
        vec_cnt++; if (spi_tx_strobe !== 1'b1 || spi_tx_data !== 8'h5A) begin err_cnt++; $display("FAIL status_resp: got %b/%h expected 1/5a", spi_tx_strobe, spi_tx_data); end
        send_byte(8'h00);
        vec_cnt++; if (spi_tx_strobe !== 1'b1 || spi_tx_data !== 8'h5A) begin err_cnt++; $display("FAIL status_repeat: got %b/%h expected 1/5a", spi_tx_strobe, spi_tx_data); end
        idle(40);
        exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 8'h5A};
        vec_cnt++; if (tx_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL stale_tx_count: got %0d expected %0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vec_cnt++;
            if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL stale_tx%0d: got %h expected %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]); end
        end
        vec_cnt++; if (req_q.size() != 1) begin err_cnt++; $display("FAIL stale_req_count: got %0d expected 1", req_q.size()); end
        cs_high();
        // Part 2: new READ while the aborted read is still in flight.
        tx_q.delete();
        req_q.delete();
        cs_low();
        send_byte(8'h03); idle(2);
        send_byte(8'h00); idle(2);
        send_byte(8'h00); idle(2);
        send_byte(8'h50);
        spi_cs = 1'b1;
        idle(5);
        cs_low();
        send_byte(8'h03); idle(2);
        send_byte(8'h00); idle(2);
        send_byte(8'h00); idle(2);
        send_byte(8'h60);
        idle(50);
        vec_cnt++; if (req_q.size() < 2 || req_q[1] !== 24'h000060) begin err_cnt++; $display("FAIL stale_deferred_addr: got %h expected 000060", (req_q.size() >= 2) ? req_q[1] : 24'hxxxxxx); end
        vec_cnt++; if (tx_q.size() != 7) begin err_cnt++; $display("FAIL stale_read_count: got %0d expected 7", tx_q.size()); end
        vec_cnt++; if (tx_q.size() < 7 || tx_q[6] !== 8'h61) begin err_cnt++; $display("FAIL stale_read_data: got %h expected 61", (tx_q.size() >= 7) ? tx_q[6] : 8'hxx); end
        vec_cnt++; if (overlap_err != 0) begin err_cnt++; $display("FAIL single_outstanding: got %0d overlaps expected 0", overlap_err); end
        cs_high();
    endtask

    task automatic test_bad_cmd_and_reset();
        tx_q.delete();
        bad_cnt = 0;
        cs_low();
        send_byte(8'hC7);
        vec_cnt++; if (bad_cmd !== 1'b1 || spi_tx_strobe !== 1'b1 || spi_tx_data !== 8'hFF) begin err_cnt++; $display("FAIL bad_cmd_pulse: got %b/%b/%h expected 1/1/ff", bad_cmd, spi_tx_strobe, spi_tx_data); end
        idle(1);
        vec_cnt++; if (bad_cmd !== 1'b0) begin err_cnt++; $display("FAIL bad_cmd_width: got %b expected 0", bad_cmd); end
        for (int i = 0; i < 2; i++) begin
            idle(5);
            send_byte(8'h03);
        end
        idle(5);
        cs_high();
        vec_cnt++; if (tx_q.size() != 4) begin err_cnt++; $display("FAIL ignore_count: got %0d expected 4", tx_q.size()); end
        for (int i = 0; i < tx_q.size(); i++) begin
            vec_cnt++;
            if (tx_q[i] !== 8'hFF) begin err_cnt++; $display("FAIL ignore_tx%0d: got %h expected ff", i, tx_q[i]); end
        end
        vec_cnt++; if (bad_cnt != 1) begin err_cnt++; $display("FAIL bad_cmd_count: got %0d expected 1", bad_cnt); end
        // Reset in the middle of a READ data phase.
        lat = 20;
        cs_low();
        send_byte(8'h03); idle(3);
        send_byte(8'h00); idle(3);
        send_byte(8'h00); idle(3);
        send_byte(8'h70);
        send_byte(8'h00);
        send_byte(8'h00);
        vec_cnt++; if (underrun !== 1'b1 || mem_addr !== 24'h000070) begin err_cnt++; $display("FAIL pre_reset_state: got %b/%h expected 1/000070", underrun, mem_addr); end
        reset = 1'b1;
        spi_cs = 1'b1;
        idle(1);
        vec_cnt++; if (spi_tx_strobe !== 1'b0) begin err_cnt++; $display("FAIL midreset_tx_strobe: got %b expected 0", spi_tx_strobe); end
        vec_cnt++; if (spi_tx_data !== 8'hFF) begin err_cnt++; $display("FAIL midreset_tx_data: got %h expected ff", spi_tx_data); end
        vec_cnt++; if (mem_rd_req !== 1'b0) begin err_cnt++; $display("FAIL midreset_mem_rd_req: got %b expected 0", mem_rd_req); end
        vec_cnt++; if (mem_addr !== 24'h0) begin err_cnt++; $display("FAIL midreset_mem_addr: got %h expected 000000", mem_addr); end
        vec_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL midreset_underrun: got %b expected 0", underrun); end
        vec_cnt++; if (bad_cmd !== 1'b0) begin err_cnt++; $display("FAIL midreset_bad_cmd: got %b expected 0", bad_cmd); end
        reset = 1'b0;
        idle(40);
        cs_low();
        vec_cnt++; if (spi_tx_strobe !== 1'b1 || spi_tx_data !== 8'hFF) begin err_cnt++; $display("FAIL post_reset_idle: got %b/%h expected 1/ff", spi_tx_strobe, spi_tx_data); end
        cs_high();
    endtask

    initial begin
        test_reset();
        test_jedec_id();
        test_read();
        test_fast_read_wrap();
        test_underrun();
        test_stale_cs();
        test_bad_cmd_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
